// File: rtl/simple_dma_pkg.sv
// Shared definitions for the simple DMA engine: state encoding and
// memory write-enable codes.
package simple_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_MEM  = 3'd3,
        ST_ACK  = 3'd4,
        ST_DONE = 3'd5
    } dma_state_e;

    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [1:0] MEM_WE_WRITE    = 2'b11;
    localparam logic [1:0] MEM_WE_READ     = 2'b00;

endpackage

// File: rtl/simple_dma_timeout.sv
// Wait-cycle counter for one memory access; flags expiry on the
// TIMEOUT-th consecutive cycle without mem_ready.
module simple_dma_timeout
    import simple_dma_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The FSM leaves MEM when this fires, so the counter never wraps.
    assign expired = enable && !clear && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/simple_dma_controller.sv
// Memory-side DMA engine: moves words between one device and the memory
// DMA port with a per-word dev_ack/dma_ack handshake.
module simple_dma_controller
    import simple_dma_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic [15:0] dev_out,
    input  logic        dev_ack,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_error_flag,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready,
    input  logic        mem_resp
);

    dma_state_e  state_q, state_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] count_q, count_d;
    logic        dir_q, dir_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [15:0] dev_in_q, dev_in_d;
    logic        expired;

    simple_dma_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ST_MEM),
        .enable  ((state_q == ST_MEM) && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        count_d    = count_q;
        dir_d      = dir_q;
        pend_d     = pend_q | dev_ack;
        err_d      = 1'b0;
        mem_din_d  = mem_din_q;
        dev_in_d   = dev_in_q;

        case (state_q)
            ST_IDLE: begin
                if (dma_rqst) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cur_addr_d = dma_start_address & 16'hFFFE;
                count_d    = dma_num_words;
                dir_d      = dma_rd_wr;
                if (!dma_rqst)                   state_d = ST_IDLE;
                else if (dma_num_words == 16'd0) state_d = ST_DONE;
                else                             state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end else if (pend_q || dev_ack) begin
                    state_d = ST_MEM;
                    pend_d  = 1'b0;
                    if (!dir_q) mem_din_d = dev_out;
                end
            end
            ST_MEM: begin
                if ((mem_ready && mem_resp) || expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (mem_ready) begin
                    if (!dma_rqst) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACK;
                        if (dir_q) dev_in_d = mem_dout;
                    end
                end
            end
            ST_ACK: begin
                count_d    = count_q - 16'd1;
                cur_addr_d = cur_addr_q + 16'd2;
                // A read's dev_ack is still held from the word just done and is
                // stale; a write pulse caught during MEM belongs to the next word.
                pend_d     = dir_q ? 1'b0 : pend_q;
                if (!dma_rqst)              state_d = ST_IDLE;
                else if (count_q == 16'd1)  state_d = ST_DONE;
                else                        state_d = ST_WAIT;
            end
            ST_DONE: begin
                if (!dma_rqst) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= 16'd0;
            count_q    <= 16'd0;
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_din_q  <= 16'd0;
            dev_in_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            mem_din_q  <= mem_din_d;
            dev_in_q   <= dev_in_d;
        end
    end

    assign mem_en         = (state_q == ST_MEM);
    assign mem_addr       = mem_en ? cur_addr_q[15:1] : 15'd0;
    assign mem_we         = (mem_en && !dir_q) ? MEM_WE_WRITE : MEM_WE_READ;
    assign mem_din        = mem_din_q;
    assign dev_in         = dev_in_q;
    assign dma_ack        = (state_q == ST_ACK);
    assign dma_end_flag   = (state_q == ST_DONE);
    assign dma_error_flag = err_q;

endmodule

// File: tb/tb_simple_dma_controller.sv
// Bench for simple_dma_controller: table of transfers against a word memory
// model, plus hand sequences for non-atomic writes, timeout and reset.
module tb_simple_dma_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_rqst, dma_rd_wr;
    logic [15:0] dma_start_address, dma_num_words;
    logic [15:0] dev_out, dev_in, mem_din, mem_dout;
    logic        dev_ack, dma_ack, dma_end_flag, dma_error_flag;
    logic [14:0] mem_addr;
    logic        mem_en, mem_ready, mem_resp;
    logic [1:0]  mem_we;

    logic [15:0] mem_model [0:32767];
    logic        ready_en, resp_en, dev_tie, dev_ack_man, cur_rd, chk_spacing;
    logic [14:0] resp_addr;
    logic [15:0] dev_out_man, wbase;
    logic [1:0]  exp_we;
    int          checks = 0, errors = 0;
    int          cyc = 0, last_ack = -1;
    int          ack_total = 0, err_total = 0, memen_total = 0;
    int          ack_base = 0, err_base = 0, memen_base = 0;
    logic [14:0] exp_addr_q [$];
    logic [15:0] exp_data_q [$];

    typedef struct {
        logic [15:0] start;
        logic [15:0] num;
        logic        rd;
        int          resp_word;
        int          exp_acks;
        int          exp_err;
        int          exp_acc;
        logic        spacing;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    assign mem_ready = mem_en & ready_en;
    assign mem_resp  = mem_en & resp_en & (mem_addr == resp_addr);
    assign mem_dout  = mem_model[mem_addr];
    assign dev_ack   = dev_tie | dev_ack_man;
    assign dev_out   = dev_tie ? (wbase + 16'(ack_total - ack_base)) : dev_out_man;

    simple_dma_controller #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dev_out           (dev_out),
        .dev_ack           (dev_ack),
        .dev_in            (dev_in),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .dma_error_flag    (dma_error_flag),
        .mem_addr          (mem_addr),
        .mem_din           (mem_din),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_dout          (mem_dout),
        .mem_ready         (mem_ready),
        .mem_resp          (mem_resp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, run the memory model and scoreboard.
    task automatic tick();
        logic [14:0] ea;
        logic [15:0] ed;
        @(negedge clk);
        cyc++;
        if (mem_en) memen_total++;
        if (mem_en && mem_ready) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_access: got addr %0h, no access expected", mem_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(ea));
                check("mem_we", 64'(mem_we), 64'(exp_we));
            end
            if (mem_we == 2'b11 && !mem_resp) mem_model[mem_addr] = mem_din;
        end
        if (dma_ack) begin
            ack_total++;
            if (cur_rd) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got dev_in %0h, no read expected", dev_in);
                end else begin
                    ed = exp_data_q.pop_front();
                    check("dev_in", 64'(dev_in), 64'(ed));
                end
            end
            if (chk_spacing && last_ack >= 0) check("ack_spacing", 64'(cyc - last_ack), 64'd3);
            last_ack = cyc;
        end
        if (dma_error_flag) err_total++;
        $display("cyc %0d en=%0b addr=%0h we=%0b ack=%0b end=%0b err=%0b dev_in=%0h",
                 cyc, mem_en, mem_addr, mem_we, dma_ack, dma_end_flag, dma_error_flag, dev_in);
    endtask

    task automatic snapshot();
        ack_base   = ack_total;
        err_base   = err_total;
        memen_base = memen_total;
        last_ack   = -1;
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic wait_end(input int budget, output int n_ticks);
        n_ticks = 0;
        while (!dma_end_flag && n_ticks < budget) begin
            tick();
            n_ticks++;
        end
        check("end_seen", 64'(dma_end_flag), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] a;
        int n_ticks;
        snapshot();
        chk_spacing = v.spacing;
        cur_rd      = v.rd;
        exp_we      = v.rd ? 2'b00 : 2'b11;
        wbase       = 16'h5A00 + 16'(idx * 16);
        resp_en     = (v.resp_word >= 0);
        a           = (v.start & 16'hFFFE) + 16'(2 * v.resp_word);
        resp_addr   = a[15:1];
        for (int i = 0; i < v.exp_acc; i++) begin
            a = (v.start & 16'hFFFE) + 16'(2 * i);
            exp_addr_q.push_back(a[15:1]);
            if (v.rd && i < v.exp_acks) exp_data_q.push_back(mem_model[a[15:1]]);
        end
        dma_start_address = v.start;
        dma_num_words     = v.num;
        dma_rd_wr         = v.rd;
        dma_rqst          = 1'b1;
        wait_end(200, n_ticks);
        if (v.exp_err != 0) check("err_with_end", 64'(dma_error_flag), 64'd1);
        if (v.num == 16'd0) check("zero_latency", 64'(n_ticks), 64'd2);
        tick();
        tick();
        check("end_held", 64'(dma_end_flag), 64'd1);
        dma_rqst = 1'b0;
        tick();
        check("end_drop", 64'(dma_end_flag), 64'd0);
        check("ack_count", 64'(ack_total - ack_base), 64'(v.exp_acks));
        check("err_count", 64'(err_total - err_base), 64'(v.exp_err));
        check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        check("data_q_empty", 64'(exp_data_q.size()), 64'd0);
        if (v.num == 16'd0) check("zero_no_mem_en", 64'(memen_total - memen_base), 64'd0);
        if (!v.rd) begin
            for (int i = 0; i < int'(v.num); i++) begin
                a = (v.start & 16'hFFFE) + 16'(2 * i);
                check("write_data", 64'(mem_model[a[15:1]]), 64'(wbase + 16'(i)));
            end
        end
        resp_en = 1'b0;
        $display("xfer %0d start=%0h num=%0d rd=%0b acks=%0d errs=%0d", idx, v.start, v.num, v.rd,
                 ack_total - ack_base, err_total - err_base);
    endtask

    initial begin
        int n;
        logic [52:0] outs;
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'(i * 3 + 16'h1000) ^ 16'hC3C3;
        mem_model[15'h100] = 16'h00A1;
        mem_model[15'h101] = 16'h00B2;
        mem_model[15'h102] = 16'h00C3;
        vecs[0] = '{16'h0200, 16'd3, 1'b1, -1, 3, 0, 3, 1'b1};
        vecs[1] = '{16'h0400, 16'd4, 1'b0, -1, 4, 0, 4, 1'b1};
        vecs[2] = '{16'hFFFE, 16'd2, 1'b1, -1, 2, 0, 2, 1'b1};
        vecs[3] = '{16'h0601, 16'd2, 1'b1, -1, 2, 0, 2, 1'b1};
        vecs[4] = '{16'h0800, 16'd3, 1'b1,  1, 1, 1, 2, 1'b0};
        vecs[5] = '{16'h1000, 16'd0, 1'b1, -1, 0, 0, 0, 1'b0};

        reset_n = 1'b0; dma_rqst = 1'b0; dma_rd_wr = 1'b0;
        dma_start_address = 16'd0; dma_num_words = 16'd0;
        ready_en = 1'b1; resp_en = 1'b0; resp_addr = 15'd0;
        dev_tie = 1'b1; dev_ack_man = 1'b0; dev_out_man = 16'd0; wbase = 16'd0;
        cur_rd = 1'b0; chk_spacing = 1'b0; exp_we = 2'b00;
        repeat (2) @(negedge clk);
        outs = {dev_in, dma_ack, dma_end_flag, dma_error_flag, mem_addr, mem_din, mem_en, mem_we};
        check("reset_outputs", 64'(outs), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Non-atomic write: single-cycle dev_ack pulses, the second during MEM.
        snapshot();
        dev_tie = 1'b0; cur_rd = 1'b0; chk_spacing = 1'b0; exp_we = 2'b11;
        exp_addr_q.push_back(15'h180);
        exp_addr_q.push_back(15'h181);
        dev_out_man = 16'h1111; dev_ack_man = 1'b1;
        dma_start_address = 16'h0300; dma_num_words = 16'd2; dma_rd_wr = 1'b0; dma_rqst = 1'b1;
        tick();
        dev_ack_man = 1'b0;
        n = 0;
        while (!mem_en && n < 20) begin tick(); n++; end
        check("nonatomic_first_mem", 64'(mem_en), 64'd1);
        dev_out_man = 16'h2222; dev_ack_man = 1'b1;
        tick();
        dev_ack_man = 1'b0;
        wait_end(50, n);
        dma_rqst = 1'b0;
        tick();
        check("nonatomic_word0", 64'(mem_model[15'h180]), 64'h1111);
        check("nonatomic_word1", 64'(mem_model[15'h181]), 64'h2222);
        check("nonatomic_acks", 64'(ack_total - ack_base), 64'd2);
        check("nonatomic_addr_q", 64'(exp_addr_q.size()), 64'd0);
        dev_tie = 1'b1;
        $display("xfer nonatomic write acks=%0d", ack_total - ack_base);

        // Timeout: memory never answers.
        snapshot();
        ready_en = 1'b0; cur_rd = 1'b1;
        dma_start_address = 16'h0A00; dma_num_words = 16'd1; dma_rd_wr = 1'b1; dma_rqst = 1'b1;
        wait_end(100, n);
        check("timeout_err_flag", 64'(dma_error_flag), 64'd1);
        check("timeout_mem_cycles", 64'(memen_total - memen_base), 64'd16);
        check("timeout_acks", 64'(ack_total - ack_base), 64'd0);
        dma_rqst = 1'b0;
        tick();
        check("timeout_end_drop", 64'(dma_end_flag), 64'd0);
        check("timeout_err_count", 64'(err_total - err_base), 64'd1);
        $display("xfer timeout mem_cycles=%0d", memen_total - memen_base);

        // Reset asserted in the middle of a stalled access.
        snapshot();
        dma_start_address = 16'h0C00; dma_num_words = 16'd1; dma_rd_wr = 1'b1; dma_rqst = 1'b1;
        n = 0;
        while (!mem_en && n < 20) begin tick(); n++; end
        check("reset_mid_mem_en", 64'(mem_en), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        outs = {dev_in, dma_ack, dma_end_flag, dma_error_flag, mem_addr, mem_din, mem_en, mem_we};
        check("reset_async_outputs", 64'(outs), 64'd0);
        dma_rqst = 1'b0; ready_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        memen_base = memen_total;
        repeat (3) tick();
        check("post_reset_idle_en", 64'(memen_total - memen_base), 64'd0);
        check("post_reset_idle_end", 64'(dma_end_flag), 64'd0);
        $display("xfer reset_mid_mem done");

        run_vec(vecs[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
